// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the pipeline hazard sequencer
//   ST_RUN / ST_MEM_WAIT : sequencer state encoding
//   NOP_INSTR            : instruction word the IF/ID register loads on a flush (addi x0,x0,0)
package hazard_ctrl_pkg;
   typedef enum logic {ST_RUN = 1'b0, ST_MEM_WAIT = 1'b1} state_t;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/hazard_ctrl_load_use.sv
// load_use_detect: flags a load in EX whose destination feeds the instruction in ID
//   in  id_ex_memread, id_ex_register_rd, if_id_register_rs1, if_id_register_rs2
//   out load_use  (x0 as destination never counts)
module load_use_detect
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  id_ex_memread,
   input  logic [REG_ADDR_W-1:0] id_ex_register_rd,
   input  logic [REG_ADDR_W-1:0] if_id_register_rs1,
   input  logic [REG_ADDR_W-1:0] if_id_register_rs2,
   output logic                  load_use
);
   always_comb begin
      load_use = id_ex_memread && id_ex_register_rd != '0 &&
                 (id_ex_register_rd == if_id_register_rs1 || id_ex_register_rd == if_id_register_rs2);
   end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencer for load-use stalls, MEM-stage branch flushes and
//   data-memory wait states with timeout.
//   in  clk, rst_n (sync, active-low), ID/EX/MEM register fields, mem_ready
//   out pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, ex_mem_flush,
//       mem_err (registered one-cycle timeout pulse)
//   HAZARD_PERF_CNT_EN adds saturating stall_cnt, flush_cnt, wait_cnt_total outputs.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
`ifdef HAZARD_PERF_CNT_EN
   parameter int CNT_W       = 32,
`endif
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] if_id_register_rs1,
   input  logic [REG_ADDR_W-1:0] if_id_register_rs2,
   input  logic [REG_ADDR_W-1:0] id_ex_register_rd,
   input  logic                  id_ex_memread,
   input  logic                  ex_mem_branch,
   input  logic                  zero_flag_ex_mem,
   input  logic                  ex_mem_memread,
   input  logic                  ex_mem_memwrite,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  pc_src,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  ex_mem_write,
   output logic                  ex_mem_flush,
`ifdef HAZARD_PERF_CNT_EN
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt,
   output logic [CNT_W-1:0]      wait_cnt_total,
`endif
   output logic                  mem_err
);
   localparam int WCW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] TMO = WCW'(MEM_TIMEOUT);

   state_t         state_q, state_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic           mem_err_q, mem_err_d;
   logic           load_use, mem_busy, taken, timeout, rel, go, stall, flush;

   load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
      .id_ex_memread      (id_ex_memread),
      .id_ex_register_rd  (id_ex_register_rd),
      .if_id_register_rs1 (if_id_register_rs1),
      .if_id_register_rs2 (if_id_register_rs2),
      .load_use           (load_use)
   );

   // rel: the pipeline may advance this cycle (no memory freeze); go additionally masks reset
   always_comb begin
      mem_busy     = (ex_mem_memread | ex_mem_memwrite) & ~mem_ready;
      taken        = ex_mem_branch & zero_flag_ex_mem;
      timeout      = state_q == ST_MEM_WAIT && wait_cnt_q == TMO && !mem_ready;
      rel          = state_q == ST_MEM_WAIT ? (mem_ready | timeout) : ~mem_busy;
      go           = rst_n & rel;
      flush        = go & taken;
      stall        = go & ~taken & load_use;
      pc_write     = go & ~stall;
      pc_src       = flush;
      if_id_write  = go & ~stall;
      if_id_flush  = flush;
      id_ex_bubble = flush | stall;
      ex_mem_write = go;
      ex_mem_flush = flush;
      state_d      = rel ? ST_RUN : ST_MEM_WAIT;
      wait_cnt_d   = state_q == ST_RUN ? WCW'(1) : (wait_cnt_q == TMO ? wait_cnt_q : wait_cnt_q + WCW'(1));
      mem_err_d    = timeout;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, wait_tot_q, wait_tot_d;

   // each counter adds one unless it is already all-ones
   always_comb begin
      stall_cnt_d = stall_cnt_q + CNT_W'(stall & ~&stall_cnt_q);
      flush_cnt_d = flush_cnt_q + CNT_W'(flush & ~&flush_cnt_q);
      wait_tot_d  = wait_tot_q + CNT_W'((state_q == ST_MEM_WAIT) & ~&wait_tot_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         wait_tot_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         wait_tot_q  <= wait_tot_d;
      end
   end

   assign stall_cnt      = stall_cnt_q;
   assign flush_cnt      = flush_cnt_q;
   assign wait_cnt_total = wait_tot_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
   localparam int TMO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [4:0] rs1, rs2, rd;
   logic       id_mr, br, zero, mr, mw, ready;
   logic       pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, ex_mem_flush, mem_err;
   logic [7:0] obs;
   int         checks = 0, failures = 0;

   bit m_wait, m_err;
   int m_cnt;

   assign obs = {pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, ex_mem_flush, mem_err};

   hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_id_register_rs1(rs1), .if_id_register_rs2(rs2), .id_ex_register_rd(rd),
      .id_ex_memread(id_mr), .ex_mem_branch(br), .zero_flag_ex_mem(zero),
      .ex_mem_memread(mr), .ex_mem_memwrite(mw), .mem_ready(ready),
      .pc_write(pc_write), .pc_src(pc_src), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
      .mem_err(mem_err)
   );

   // Expected outputs this cycle, bit order as obs
   function automatic logic [7:0] model_out();
      bit busy, adv_ok, tk, lu;
      busy   = (mr || mw) && !ready;
      adv_ok = rst_n && (m_wait ? (ready || m_cnt == TMO) : !busy);
      tk     = adv_ok && br && zero;
      lu     = adv_ok && !tk && id_mr && rd != 0 && (rd == rs1 || rd == rs2);
      return {adv_ok && !lu, tk, adv_ok && !lu, tk, tk || lu, adv_ok, tk, m_err};
   endfunction

   task automatic adv();
      bit busy;
      @(posedge clk);
      busy = (mr || mw) && !ready;
      if (!rst_n) begin
         m_wait = 0; m_cnt = 0; m_err = 0;
      end else if (!m_wait) begin
         m_err = 0;
         if (busy) begin m_wait = 1; m_cnt = 1; end
      end else if (ready) begin
         m_wait = 0; m_err = 0;
      end else if (m_cnt == TMO) begin
         m_wait = 0; m_err = 1;
      end else begin
         m_cnt++; m_err = 0;
      end
      #1;
   endtask

   task automatic idle();
      rst_n = 1; rs1 = 1; rs2 = 2; rd = 3; id_mr = 0; br = 0; zero = 0; mr = 0; mw = 0; ready = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; rs1 = '1; rs2 = '1; rd = '1; id_mr = 1; br = 1; zero = 1; mr = 1; mw = 1; ready = 1;
      adv();
      for (int i = 0; i < 2; i++) begin
         #3; checks++;
         if (obs !== 8'h00) begin failures++; $display("FAIL reset cyc=%0d got=%b exp=%b", i, obs, 8'h00); end
         adv();
      end
      idle();
      #3; checks++;
      if (obs !== 8'hA4) begin failures++; $display("FAIL reset_release got=%b exp=%b", obs, 8'hA4); end
      adv();
   endtask

   task automatic test_load_use();
      logic [7:0] exp_v [3] = '{8'h0C, 8'hA4, 8'hA4};
      for (int i = 0; i < 3; i++) begin
         idle();
         if (i == 0) begin id_mr = 1; rd = 5; rs1 = 5; end
         if (i == 2) begin id_mr = 1; rd = 0; rs1 = 0; end
         #3; checks++;
         if (obs !== exp_v[i] || obs !== model_out())
            begin failures++; $display("FAIL load_use step=%0d got=%b exp=%b", i, obs, exp_v[i]); end
         adv();
      end
   endtask

   task automatic test_branch();
      logic [7:0] exp_v [2] = '{8'hFE, 8'hA4};
      for (int i = 0; i < 2; i++) begin
         idle(); br = 1; zero = (i == 0);
         #3; checks++;
         if (obs !== exp_v[i]) begin failures++; $display("FAIL branch zero=%0d got=%b exp=%b", zero, obs, exp_v[i]); end
         adv();
      end
   endtask

   task automatic test_mem_wait();
      for (int i = 0; i < 5; i++) begin
         idle(); mr = (i < 4); ready = (i >= 3);
         #3; checks++;
         if (obs !== (i < 3 ? 8'h00 : 8'hA4))
            begin failures++; $display("FAIL mem_wait cyc=%0d got=%b exp=%b", i, obs, (i < 3 ? 8'h00 : 8'hA4)); end
         adv();
      end
   endtask

   task automatic test_timeout();
      logic [7:0] exp_v [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA4, 8'hA5, 8'hA4};
      for (int i = 0; i < 7; i++) begin
         idle(); mr = (i < 5);
         #3; checks++;
         if (obs !== exp_v[i]) begin failures++; $display("FAIL timeout cyc=%0d got=%b exp=%b", i, obs, exp_v[i]); end
         adv();
      end
   endtask

   task automatic test_branch_vs_load_use();
      idle(); br = 1; zero = 1; id_mr = 1; rd = 7; rs2 = 7;
      #3; checks++;
      if (obs !== 8'hFE) begin failures++; $display("FAIL branch_vs_lu got=%b exp=%b", obs, 8'hFE); end
      adv();
   endtask

   task automatic test_reset_mid_wait();
      for (int i = 0; i < 9; i++) begin
         idle(); mr = (i < 2); rst_n = (i != 2);
         #3; checks++;
         if (obs !== (i < 3 ? 8'h00 : 8'hA4))
            begin failures++; $display("FAIL reset_mid_wait cyc=%0d got=%b exp=%b", i, obs, (i < 3 ? 8'h00 : 8'hA4)); end
         adv();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst_n = $urandom_range(0, 49) != 0;
         rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
         id_mr = $urandom_range(0, 1) == 1; br = $urandom_range(0, 2) == 0; zero = $urandom_range(0, 1) == 1;
         mr = $urandom_range(0, 2) == 0; mw = $urandom_range(0, 3) == 0; ready = $urandom_range(0, 9) < 3;
         #3; checks++;
         if (obs !== model_out()) begin failures++; $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, model_out()); end
         adv();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_branch_vs_load_use();
      test_reset_mid_wait();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
